// File: rtl/tt_um_count_checker.sv
// Receive-side checker for the +1-per-sample counter pattern: seeds on the first valid
// sample, locks after LOCK_COUNT consecutive increments, counts sequence errors while locked.
// Ports: clk/rst (async active-high), ena (unused), ui_in = sample, uio_in = {-,sel,clr,valid},
// uo_out = registered last sample or err_cnt, uio_out = registered status, uio_oe = 8'hF0.
module tt_um_count_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] prev, prev_nxt;
    logic [3:0] match_cnt, match_nxt;
    logic [3:0] miss_cnt, miss_nxt;
    logic [7:0] err_cnt, err_nxt;
    logic [7:0] last, last_nxt;
    logic       err_pulse_nxt;
    logic       err_inc;

    logic valid, clr, sel, hit;
    logic unused;

    assign valid  = uio_in[0];
    assign clr    = uio_in[1];
    assign sel    = uio_in[2];
    assign hit    = (ui_in == prev + 8'd1);   // wraps naturally, so FF -> 00 matches
    assign uio_oe = 8'hF0;
    assign unused = ^{ena, uio_in[7:3]};

    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        match_nxt     = match_cnt;
        miss_nxt      = miss_cnt;
        last_nxt      = last;
        err_inc       = 1'b0;
        err_pulse_nxt = 1'b0;

        if (valid) begin
            last_nxt = ui_in;
            case (state)
                SEARCH: begin
                    prev_nxt  = ui_in;
                    match_nxt = 4'd0;
                    state_nxt = LOCKING;
                end
                LOCKING: begin
                    // Mismatches here just re-seed; no errors are counted before lock.
                    prev_nxt = ui_in;
                    if (hit) begin
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
                            state_nxt = LOCKED;
                            miss_nxt  = 4'd0;
                        end
                    end else begin
                        match_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        prev_nxt = ui_in;
                        miss_nxt = 4'd0;
                    end else begin
                        // Flywheel: keep predicting so one corrupted sample costs one error.
                        prev_nxt      = prev + 8'd1;
                        err_inc       = 1'b1;
                        err_pulse_nxt = 1'b1;
                        miss_nxt      = miss_cnt + 4'd1;
                        if (miss_cnt + 4'd1 == 4'(LOSS_COUNT)) begin
                            state_nxt = SEARCH;
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end

        // clr beats a same-cycle increment; the pulse above still reports the error.
        if (clr) begin
            err_nxt = 8'd0;
        end else if (err_inc && err_cnt != 8'hFF) begin
            err_nxt = err_cnt + 8'd1;
        end else begin
            err_nxt = err_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            prev      <= 8'd0;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            err_cnt   <= 8'd0;
            last      <= 8'd0;
            uo_out    <= 8'd0;
            uio_out   <= 8'd0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err_cnt   <= err_nxt;
            last      <= last_nxt;
            // Output registers are loaded from the next-state values so that pins
            // reflect the sample taken on this edge from the following cycle on.
            uo_out    <= sel ? err_nxt : last_nxt;
            uio_out   <= {(err_nxt == 8'hFF), err_pulse_nxt,
                          (state_nxt == LOCKING), (state_nxt == LOCKED), 4'b0000};
        end
    end

endmodule

// File: tb/tb_tt_um_count_checker.sv
module tb_tt_um_count_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_a, uio_a, oe_a;
    logic [7:0] uo_b, uio_b, oe_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Default parameters.
    tt_um_count_checker dut_a (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_a), .uio_out(uio_a), .uio_oe(oe_a)
    );

    // Tolerant loss count, used to accumulate many errors without dropping lock.
    tt_um_count_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_b), .uio_out(uio_b), .uio_oe(oe_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 = hunting for a seed, 1 = acquiring, 2 = tracking.
    int         m_phase [2];
    int         m_run   [2];   // consecutive good increments while acquiring
    int         m_bad   [2];   // consecutive bad samples while tracking
    int         m_expect[2];   // value the next sample should carry (0..255)
    int         m_errs  [2];
    int         m_last  [2];
    bit         m_pulse [2];
    logic [7:0] m_uo    [2];
    logic [7:0] m_uio   [2];
    int         m_loss  [2];

    localparam int LOCKN = 4;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_run[k] = 0; m_bad[k] = 0; m_expect[k] = 1;
            m_errs[k] = 0; m_last[k] = 0; m_pulse[k] = 0;
            m_uo[k] = 8'd0; m_uio[k] = 8'd0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input int s, input bit c, input bit sl);
        bit bad_one;
        bad_one    = 0;
        m_pulse[k] = 0;
        if (v) begin
            m_last[k] = s;
            if (m_phase[k] == 0) begin
                m_phase[k] = 1; m_run[k] = 0; m_expect[k] = (s + 1) % 256;
            end else if (m_phase[k] == 1) begin
                m_run[k]    = (s == m_expect[k]) ? m_run[k] + 1 : 0;
                m_expect[k] = (s + 1) % 256;
                if (m_run[k] == LOCKN) begin
                    m_phase[k] = 2; m_bad[k] = 0;
                end
            end else begin
                if (s == m_expect[k]) begin
                    m_bad[k] = 0;
                end else begin
                    bad_one = 1; m_pulse[k] = 1; m_bad[k]++;
                    if (m_bad[k] == m_loss[k]) m_phase[k] = 0;
                end
                m_expect[k] = (m_expect[k] + 1) % 256;
            end
        end
        if (c) m_errs[k] = 0;
        else if (bad_one && m_errs[k] < 255) m_errs[k]++;
        m_uo[k]  = sl ? 8'(m_errs[k]) : 8'(m_last[k]);
        m_uio[k] = {(m_errs[k] == 255), m_pulse[k], (m_phase[k] == 1), (m_phase[k] == 2), 4'b0000};
    endtask

    task automatic compare_all();
        check("uo_a", uo_a, m_uo[0]);
        check("uio_a", uio_a, m_uio[0]);
        check("uo_b", uo_b, m_uo[1]);
        check("uio_b", uio_b, m_uio[1]);
    endtask

    // Drive at a falling edge, sample on the next rising edge, compare at the next falling edge.
    task automatic cycle(input bit v, input int s, input bit c, input bit sl);
        ui_in  = 8'(s);
        uio_in = {5'b00000, sl, c, v};
        @(posedge clk);
        model_step(0, v, s, c, sl);
        model_step(1, v, s, c, sl);
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        uio_in = 8'd0;
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        int tx;
        m_loss[0] = 3;
        m_loss[1] = 15;
        model_reset();
        @(negedge clk);
        check("uio_oe", oe_a, 8'hF0);

        // Lock on 10..14.
        do_reset();
        cycle(1, 10, 0, 0);
        check("lock_locking", {7'd0, uio_a[5]}, 8'd1);
        for (int i = 11; i <= 14; i++) cycle(1, i, 0, 0);
        check("lock_locked", {7'd0, uio_a[4]}, 8'd1);
        check("lock_uo14", uo_a, 8'd14);
        cycle(0, 0, 0, 1);
        check("lock_err0", uo_a, 8'd0);

        // Wrap and gaps.
        do_reset();
        for (int i = 252; i <= 256; i++) cycle(1, i % 256, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check("wrap_locked", {7'd0, uio_a[4]}, 8'd1);
        check("wrap_nopulse", {7'd0, uio_a[6]}, 8'd0);

        // Flywheel error.
        do_reset();
        for (int i = 16; i <= 20; i++) cycle(1, i, 0, 0);
        cycle(1, 21, 0, 1);
        cycle(1, 99, 0, 1);
        check("fly_pulse", {7'd0, uio_a[6]}, 8'd1);
        cycle(1, 23, 0, 1);
        check("fly_nopulse", {7'd0, uio_a[6]}, 8'd0);
        check("fly_locked", {7'd0, uio_a[4]}, 8'd1);
        check("fly_err1", uo_a, 8'd1);

        // Loss of lock.
        do_reset();
        for (int i = 36; i <= 40; i++) cycle(1, i, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 7, 0, 1);
        check("loss_err3", uo_a, 8'd3);
        check("loss_unlocked", {7'd0, uio_a[4]}, 8'd0);
        cycle(1, 50, 0, 1);
        check("loss_relocking", {7'd0, uio_a[5]}, 8'd1);

        // Saturation and clear on the tolerant instance.
        do_reset();
        for (int i = 0; i <= 4; i++) cycle(1, i, 0, 0);
        for (int r = 0; r < 19; r++) begin
            for (int j = 0; j < 14; j++) cycle(1, (m_expect[1] + 100) % 256, 0, 1);
            cycle(1, m_expect[1], 0, 1);
        end
        check("sat_uo", uo_b, 8'hFF);
        check("sat_flag", {7'd0, uio_b[7]}, 8'd1);
        cycle(1, (m_expect[1] + 7) % 256, 1, 1);
        check("clr_err0", uo_b, 8'd0);
        check("clr_pulse", {7'd0, uio_b[6]}, 8'd1);
        check("clr_nosat", {7'd0, uio_b[7]}, 8'd0);

        // Async reset while locked with five errors.
        do_reset();
        for (int i = 0; i <= 4; i++) cycle(1, i, 0, 1);
        cycle(1, 200, 0, 1); cycle(1, 200, 0, 1); cycle(1, m_expect[0], 0, 1);
        cycle(1, 200, 0, 1); cycle(1, 200, 0, 1); cycle(1, m_expect[0], 0, 1);
        cycle(1, 200, 0, 1);
        check("pre_rst_err5", uo_a, 8'd5);
        check("pre_rst_locked", {7'd0, uio_a[4]}, 8'd1);
        uio_in = 8'h04;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst_uo", uo_a, 8'd0);
        check("arst_uio", uio_a, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 77, 0, 0);
        check("arst_search_seed", uio_a, 8'h20);

        // Randomized traffic: mostly a clean count with drops, corruptions and jumps.
        do_reset();
        tx = $urandom_range(0, 255);
        for (int n = 0; n < 2500; n++) begin
            bit v, c, sl;
            int r, s;
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 59) == 0);
            sl = $urandom_range(0, 1);
            r  = $urandom_range(0, 99);
            if (r < 82)      s = tx;
            else if (r < 94) s = $urandom_range(0, 255);
            else begin tx = $urandom_range(0, 255); s = tx; end
            if (v) tx = (tx + 1) % 256;
            cycle(v, s, c, sl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
